// File: rtl/crossfade_seq_pkg.sv
// ============================================================================
// Module  : crossfade_seq_pkg
// Brief   : Shared state encoding, level limits and saturating helpers for
//           the crossfade sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package crossfade_seq_pkg;

  typedef enum logic [1:0] {
    HOLD_1    = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD_2    = 2'd2,
    RAMP_DOWN = 2'd3
  } seq_state_t;

  localparam logic [7:0] LEVEL_MIN = 8'd0;
  localparam logic [7:0] LEVEL_MAX = 8'd255;

  // Add with clamp at LEVEL_MAX so the level can never wrap upward.
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? LEVEL_MAX : s[7:0];
  endfunction

  // Subtract with clamp at LEVEL_MIN so the level can never wrap downward.
  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? LEVEL_MIN : (a - b);
  endfunction

endpackage

`default_nettype wire

// File: rtl/crossfade_sequencer_tick_divider.sv
// ============================================================================
// Module  : tick_divider
// Brief   : Counts sample ticks against a rate latched at ramp entry and
//           strobes once every rate+1 ticks.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tick_divider #(
  parameter int RATE_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [RATE_W-1:0] i_rate,
  input  logic              i_tick,
  output logic              o_step
);

  logic [RATE_W-1:0] r_cnt;
  logic [RATE_W-1:0] r_rate;

  // Step on the tick that finds the counter already at the latched rate.
  assign o_step = i_tick && (r_cnt == r_rate);

  // Counter and rate latch; clear wins over tick so a restart never steps.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_rate <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
      if (i_load) begin
        r_rate <= i_rate;
      end
    end else if (i_tick) begin
      if (r_cnt == r_rate) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/crossfade_sequencer.sv
// ============================================================================
// Module  : crossfade_sequencer
// Brief   : Ramps an 8-bit crossfader level between 0 and 255 following sel_i,
//           one STEP every rate+1 sample ticks.
// Config  : CROSSFADE_SEQ_REVERSE_EN - reverse a ramp in flight when sel_i
//           flips instead of finishing it first.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module crossfade_sequencer
  import crossfade_seq_pkg::*;
#(
  parameter int STEP   = 1,
  parameter int RATE_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              sample_tick_i,
  input  logic              sel_i,
  input  logic [RATE_W-1:0] rate_i,
  output logic [7:0]        level_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [7:0] c_STEP = 8'(STEP);

  seq_state_t r_state;
  seq_state_t w_state_nxt;
  logic [7:0] r_level;
  logic [7:0] w_level_nxt;
  logic       r_busy;
  logic       w_busy_nxt;
  logic       r_done;
  logic       w_done_nxt;
  logic       w_in_ramp;
  logic       w_load;
  logic       w_reverse;
  logic       w_clear;
  logic       w_div_tick;
  logic       w_step;
  logic [7:0] w_lvl_up;
  logic [7:0] w_lvl_dn;

  assign w_in_ramp = (r_state == RAMP_UP) || (r_state == RAMP_DOWN);
  assign w_load    = ((r_state == HOLD_1) && sel_i) || ((r_state == HOLD_2) && !sel_i);

`ifdef CROSSFADE_SEQ_REVERSE_EN
  assign w_reverse = ((r_state == RAMP_UP) && !sel_i) || ((r_state == RAMP_DOWN) && sel_i);
`else
  assign w_reverse = 1'b0;
`endif

  // Ticks only count while ramping; a reversal swallows its cycle's tick.
  assign w_clear    = w_load || w_reverse;
  assign w_div_tick = sample_tick_i && w_in_ramp && !w_reverse;
  assign w_lvl_up   = sat_add(r_level, c_STEP);
  assign w_lvl_dn   = sat_sub(r_level, c_STEP);

  tick_divider #(
    .RATE_W (RATE_W)
  ) u_tick_divider (
    .i_clk   (clk_i),
    .i_rst_n (rst_n_i),
    .i_clear (w_clear),
    .i_load  (w_load),
    .i_rate  (rate_i),
    .i_tick  (w_div_tick),
    .o_step  (w_step)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= HOLD_1;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: start on a sel mismatch, finish when a step hits the endpoint.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      HOLD_1:    if (sel_i) w_state_nxt = RAMP_UP;
      RAMP_UP: begin
        if (w_reverse) begin
          w_state_nxt = RAMP_DOWN;
        end else if (w_step && (w_lvl_up == LEVEL_MAX)) begin
          w_state_nxt = HOLD_2;
        end
      end
      HOLD_2:    if (!sel_i) w_state_nxt = RAMP_DOWN;
      RAMP_DOWN: begin
        if (w_reverse) begin
          w_state_nxt = RAMP_UP;
        end else if (w_step && (w_lvl_dn == LEVEL_MIN)) begin
          w_state_nxt = HOLD_1;
        end
      end
      default:   w_state_nxt = HOLD_1;
    endcase
  end

  // Output decode, computed one cycle ahead so the outputs can be registered.
  always_comb begin
    w_level_nxt = r_level;
    if (w_step) begin
      if (r_state == RAMP_UP) begin
        w_level_nxt = w_lvl_up;
      end else if (r_state == RAMP_DOWN) begin
        w_level_nxt = w_lvl_dn;
      end
    end
    w_busy_nxt = (w_state_nxt == RAMP_UP) || (w_state_nxt == RAMP_DOWN);
    w_done_nxt = ((r_state == RAMP_UP)   && (w_state_nxt == HOLD_2)) ||
                 ((r_state == RAMP_DOWN) && (w_state_nxt == HOLD_1));
  end

  // Registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_level <= LEVEL_MIN;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_level <= w_level_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign level_o = r_level;
  assign busy_o  = r_busy;
  assign done_o  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_crossfade_sequencer.sv
// ============================================================================
// Module  : tb_crossfade_sequencer
// Brief   : Directed bench for crossfade_sequencer with STEP=1 and STEP=16
//           instances sharing clock, reset, tick and rate.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_crossfade_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       sel1 = 1'b0;
  logic       sel16 = 1'b0;
  logic [7:0] rate = 8'd0;
  logic [7:0] level1, level16;
  logic       busy1, busy16, done1, done16;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done1  = 0;

  always #5 clk = ~clk;

  crossfade_sequencer #(.STEP(1), .RATE_W(8)) u_dut1 (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .sample_tick_i (tick),
    .sel_i         (sel1),
    .rate_i        (rate),
    .level_o       (level1),
    .busy_o        (busy1),
    .done_o        (done1)
  );

  crossfade_sequencer #(.STEP(16), .RATE_W(8)) u_dut16 (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .sample_tick_i (tick),
    .sel_i         (sel16),
    .rate_i        (rate),
    .level_o       (level16),
    .busy_o        (busy16),
    .done_o        (done16)
  );

  // Count done pulses of the STEP=1 instance.
  always @(negedge clk) if (done1) n_done1++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One tick straddling one rising edge; returns at the falling edge after it.
  task automatic do_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_level", level1, 0);
    check_val("rst_busy", busy1, 0);
    check_val("rst_done", done1, 0);
    rst_n = 1'b1;

    // Idle with sel=0 for 100 ticks
    do_ticks(100);
    check_val("idle_level", level1, 0);
    check_val("idle_busy", busy1, 0);
    check_val("idle_done_cnt", n_done1, 0);

    // Full up ramp, STEP=1, rate=0
    rate = 8'd0;
    sel1 = 1'b1;
    @(negedge clk);
    check_val("up_busy_rise", busy1, 1);
    check_val("up_level_start", level1, 0);
    do_ticks(254);
    check_val("up_level_254", level1, 254);
    check_val("up_busy_mid", busy1, 1);
    do_tick();
    check_val("up_level_255", level1, 255);
    check_val("up_done", done1, 1);
    check_val("up_busy_end", busy1, 0);
    @(negedge clk);
    check_val("up_done_1cyc", done1, 0);
    do_ticks(5);
    check_val("hold2_level", level1, 255);
    check_val("up_done_cnt", n_done1, 1);

    // Down ramp with rate 2, changed to 9 after entry
    rate = 8'd2;
    sel1 = 1'b0;
    @(negedge clk);
    check_val("dn_busy_rise", busy1, 1);
    rate = 8'd9;
    do_ticks(2);
    check_val("dn_lvl_2t", level1, 255);
    do_tick();
    check_val("dn_lvl_3t", level1, 254);
    do_ticks(2);
    check_val("dn_lvl_5t", level1, 254);
    do_tick();
    check_val("dn_lvl_6t", level1, 253);
    do_ticks(758);
    check_val("dn_lvl_764t", level1, 1);
    do_tick();
    check_val("dn_lvl_end", level1, 0);
    check_val("dn_done", done1, 1);
    check_val("dn_busy_end", busy1, 0);

    // Next ramp latches rate 9: 10 ticks per step
    sel1 = 1'b1;
    @(negedge clk);
    check_val("r9_busy", busy1, 1);
    do_ticks(9);
    check_val("r9_lvl_9t", level1, 0);
    do_tick();
    check_val("r9_lvl_10t", level1, 1);
    do_ticks(1270);
    check_val("r9_lvl_128", level1, 128);

    // Asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_level", level1, 0);
    check_val("arst_busy", busy1, 0);
    check_val("arst_done", done1, 0);
    rate = 8'd0;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check_val("rel_busy", busy1, 1);
    check_val("rel_level", level1, 0);
    do_tick();
    check_val("rel_lvl_1", level1, 1);
    do_ticks(99);
    check_val("mid_lvl_100", level1, 100);

    // Toggle sel mid-ramp at level 100
    sel1 = 1'b0;
`ifdef CROSSFADE_SEQ_REVERSE_EN
    @(negedge clk);
    check_val("rev_busy", busy1, 1);
    check_val("rev_level", level1, 100);
    check_val("rev_no_done", done1, 0);
    do_tick();
    check_val("rev_lvl_99", level1, 99);
    do_ticks(98);
    check_val("rev_lvl_1", level1, 1);
    do_tick();
    check_val("rev_lvl_0", level1, 0);
    check_val("rev_done", done1, 1);
`else
    do_tick();
    check_val("cont_lvl_101", level1, 101);
    do_ticks(154);
    check_val("cont_lvl_255", level1, 255);
    check_val("cont_done", done1, 1);
    check_val("cont_busy_low", busy1, 0);
    @(negedge clk);
    check_val("cont_dn_busy", busy1, 1);
    check_val("cont_dn_done", done1, 0);
    check_val("cont_dn_level", level1, 255);
    do_tick();
    check_val("cont_dn_254", level1, 254);
`endif

    // STEP=16, rate=3
    check_val("s16_idle_level", level16, 0);
    rate  = 8'd3;
    sel16 = 1'b1;
    @(negedge clk);
    check_val("s16_busy", busy16, 1);
    do_ticks(3);
    check_val("s16_lvl_3t", level16, 0);
    do_tick();
    check_val("s16_lvl_4t", level16, 16);
    do_ticks(56);
    check_val("s16_lvl_60t", level16, 240);
    do_ticks(3);
    check_val("s16_lvl_63t", level16, 240);
    do_tick();
    check_val("s16_lvl_64t", level16, 255);
    check_val("s16_done", done16, 1);
    check_val("s16_busy_end", busy16, 0);
    do_ticks(8);
    check_val("s16_nowrap", level16, 255);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/crossfade_sequencer.md
CROSSFADE_SEQUENCER -- requirements
Module: crossfade_sequencer

Interface
REQ-001 The block SHALL have parameter STEP, default 1; level increment/decrement per ramp step, legal range 1..255.
REQ-002 The block SHALL have parameter RATE_W, default 8; width of the step-period input.
REQ-003 The block SHALL have port clk_i, input, 1 bit; the single clock.
REQ-004 The block SHALL have port rst_n_i, input, 1 bit; asynchronous, active-low reset.
REQ-005 The block SHALL have port sample_tick_i, input, 1 bit; one-cycle strobe, one per audio sample.
REQ-006 The block SHALL have port sel_i, input, 1 bit; target source, level-sensitive (0 = data_1 path, 1 = data_2 path).
REQ-007 The block SHALL have port rate_i, input, RATE_W bits; a step is taken every rate_i+1 sample ticks.
REQ-008 The block SHALL have port level_o, output, 8 bits; mix level driven to the crossfader level input.
REQ-009 The block SHALL have port busy_o, output, 1 bit; high while ramping.
REQ-010 The block SHALL have port done_o, output, 1 bit; one-cycle pulse when a ramp reaches its endpoint.

Function
REQ-011 The FSM SHALL have exactly four states: HOLD_1 (level_o=0), RAMP_UP, HOLD_2 (level_o=255), RAMP_DOWN.
REQ-012 In HOLD_1 with sel_i=1, the FSM SHALL enter RAMP_UP on the next clock edge; in HOLD_2 with sel_i=0, it SHALL enter RAMP_DOWN.
REQ-013 On ramp entry, rate_i SHALL be latched into a rate register and the tick counter SHALL be cleared; rate_i changes mid-ramp SHALL have no effect.
REQ-014 The tick counter SHALL increment only on sample_tick_i; on a tick with counter == latched rate, the block SHALL take one step and clear the counter.
REQ-015 In RAMP_UP, a step SHALL add STEP with saturation at 255; in RAMP_DOWN, a step SHALL subtract STEP with saturation at 0; level_o SHALL never wrap.
REQ-016 When a step makes level_o reach 255 in RAMP_UP, the FSM SHALL enter HOLD_2; reaching 0 in RAMP_DOWN SHALL enter HOLD_1; done_o SHALL pulse in the cycle after that step.
REQ-017 Full-ramp duration SHALL be ceil(255/STEP)*(rate+1) sample ticks, measured from ramp entry.
REQ-018 busy_o SHALL equal 1 exactly in RAMP_UP and RAMP_DOWN.
REQ-019 level_o, busy_o and done_o SHALL all be registered outputs.
REQ-020 With rate_i=0, the block SHALL step on every sample tick.
REQ-021 In HOLD states, sample_tick_i SHALL be ignored and level_o SHALL stay constant.

Reset
REQ-022 Asserting rst_n_i low SHALL asynchronously force state to HOLD_1, level_o=0, busy_o=0, done_o=0, counter=0 and rate register=0, including mid-ramp.
REQ-023 After release, the first transition SHALL follow REQ-012 based on the current sel_i.

Configuration
REQ-024 Macro CROSSFADE_SEQ_REVERSE_EN defined: when sel_i opposes the current ramp direction, the FSM SHALL switch RAMP_UP<->RAMP_DOWN on the next edge, keep level_o, and clear the counter; done_o SHALL NOT pulse on reversal.
REQ-025 Macro CROSSFADE_SEQ_REVERSE_EN undefined: the ramp in progress SHALL complete; the opposite ramp SHALL then start from the HOLD state on the cycle after arrival, if sel_i is still opposite.

Structure
REQ-026 Package crossfade_seq_pkg SHALL hold the state enum type and constants LEVEL_MIN=0 and LEVEL_MAX=255.
REQ-027 The tick counter and latched rate SHALL be a sub-module tick_divider (inputs clear and tick; output step strobe).

Verification
REQ-028 Reset, then sel_i=0 held for 100 ticks -> level_o=0, busy_o=0, done_o never asserted.
REQ-029 STEP=1, rate_i=0, sel_i 0->1 -> busy_o rises next cycle; level_o reaches 255 after 255 ticks; single done_o pulse; HOLD_2 entered.
REQ-030 STEP=16, rate_i=3 -> level_o steps 16 every 4 ticks, saturates at 255 after 64 ticks, no wrap.
REQ-031 Mid-ramp at level_o=100, toggle sel_i to 0 -> with CROSSFADE_SEQ_REVERSE_EN, level_o decreases from 100 with no done_o; without it, level_o continues to 255, done_o pulses, then RAMP_DOWN starts.
REQ-032 rst_n_i pulled low asynchronously at level_o=128 (between clock edges) -> level_o=0, busy_o=0 immediately; after release with sel_i=1, a fresh ramp starts from 0.
REQ-033 rate_i changed from 2 to 9 mid-ramp -> step period stays 3 ticks until the ramp ends; the next ramp uses 10 ticks.
